fb_scanout: RTL

- Display-side reader for the colour-index framebuffer that the Mandelbrot renderer writes.
- Once per framebuffer row, fetches that row from framebuffer memory into an internal line buffer during horizontal blanking.
- During active video, streams colour indices out, with each framebuffer pixel repeated SCALE times horizontally and vertically (320x180 to 1280x720).
- Sits between the framebuffer read port and the display palette/TMDS path.

---
 rtl/fb_scanout_if.sv | 13 +
 rtl/fb_scanout.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fb_scanout_if.sv
// Framebuffer read port. The scanout side drives address/strobe (master);
// the memory returns data RD_LAT cycles later (slave).
interface fb_scanout_if #(
    parameter int ADDRW = 16,
    parameter int CIDXW = 8
);
    logic [ADDRW-1:0] fb_addr;
    logic             fb_rd;
    logic [CIDXW-1:0] fb_data;

    modport master (output fb_addr, output fb_rd, input fb_data);
    modport slave  (input fb_addr, input fb_rd, output fb_data);
endinterface

// File: rtl/fb_scanout.sv
// Framebuffer scanout: fetches one framebuffer row per SCALE display lines into a
// line buffer during hblank, then streams it out with SCALE x SCALE pixel replication.
module fb_scanout #(
    parameter int CORDW     = 16,
    parameter int FB_WIDTH  = 320,
    parameter int FB_HEIGHT = 180,
    parameter int CIDXW     = 8,
    parameter int SCALE     = 4,
    parameter int RD_LAT    = 2,
    parameter int ADDRW     = $clog2(FB_WIDTH*FB_HEIGHT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame,
    input  logic             line,
    input  logic             de,
    fb_scanout_if.master     fb,
    output logic [CIDXW-1:0] pix_cidx,
    output logic             pix_de,
    output logic             busy,
    output logic             underrun
);
    localparam int IDXW = (FB_WIDTH > 1) ? $clog2(FB_WIDTH) : 1;
    localparam int COLW = $clog2(FB_WIDTH + 1);
    localparam int SUBW = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam logic [IDXW-1:0]  COL_LAST = IDXW'(FB_WIDTH - 1);
    localparam logic [COLW-1:0]  COL_END  = COLW'(FB_WIDTH);
    localparam logic [SUBW-1:0]  SUB_LAST = SUBW'(SCALE - 1);
    localparam logic [CORDW-1:0] ROW_END  = CORDW'(FB_HEIGHT);
    localparam logic [CORDW-1:0] ROW_LAST = CORDW'(FB_HEIGHT - 1);
    localparam logic [ADDRW-1:0] ROW_STEP = ADDRW'(FB_WIDTH);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t           state_reg, state_next;
    logic [IDXW-1:0]  rd_col_reg, rd_col_next;
    logic [ADDRW-1:0] fetch_base_reg, row_base_reg;
    logic [SUBW-1:0]  line_sub_reg;
    logic [CORDW-1:0] line_row_reg;
    logic             row_valid_reg;
    logic             underrun_reg;
    logic             need_fetch, rd_active, flush, last_wr;

    logic [RD_LAT-1:0] vld_pipe, vld_in;
    logic [IDXW-1:0]   idx_pipe [RD_LAT];
    logic [IDXW-1:0]   idx_in   [RD_LAT];

    logic [CIDXW-1:0] lbuf [FB_WIDTH];
    logic [CIDXW-1:0] lbuf_rd;
    logic             de_q_reg, pix_de_reg, pix_valid_reg;
    logic [COLW-1:0]  px_col_reg, cur_col;
    logic [SUBW-1:0]  px_sub_reg, cur_sub;
    logic [IDXW-1:0]  rd_idx;

    assign need_fetch = (line_sub_reg == '0) && (line_row_reg < ROW_END);
    assign rd_active  = (state_reg == FETCH);
    assign busy       = (state_reg != IDLE);
    assign flush      = frame || (line && busy);
    assign last_wr    = vld_pipe[RD_LAT-1] && (idx_pipe[RD_LAT-1] == COL_LAST);
    assign underrun   = underrun_reg;

    assign fb.fb_rd   = rd_active;
    assign fb.fb_addr = rd_active ? fetch_base_reg + ADDRW'(rd_col_reg) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            rd_col_reg <= '0;
        end else begin
            state_reg  <= state_next;
            rd_col_reg <= rd_col_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        rd_col_next = rd_col_reg;
        case (state_reg)
            IDLE: ;
            FETCH: begin
                rd_col_next = rd_col_reg + 1'b1;
                if (rd_col_reg == COL_LAST) state_next = DRAIN;
            end
            DRAIN: if (last_wr) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // A new line always restarts from column 0, abandoning any partial fetch.
        if (line) begin
            state_next  = need_fetch ? FETCH : IDLE;
            rd_col_next = '0;
        end
        if (frame) begin
            state_next  = IDLE;
            rd_col_next = '0;
        end
    end

    // Line bookkeeping: sub-counter within a row and row counter instead of a divide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_sub_reg   <= '0;
            line_row_reg   <= '0;
            row_base_reg   <= '0;
            fetch_base_reg <= '0;
            row_valid_reg  <= 1'b0;
            underrun_reg   <= 1'b0;
        end else begin
            if (frame) begin
                line_sub_reg  <= '0;
                line_row_reg  <= '0;
                row_base_reg  <= '0;
                row_valid_reg <= 1'b0;
            end else if (line) begin
                row_valid_reg <= (line_row_reg < ROW_END);
                if (need_fetch) fetch_base_reg <= row_base_reg;
                if (line_sub_reg == SUB_LAST) begin
                    line_sub_reg <= '0;
                    if (line_row_reg < ROW_END)  line_row_reg <= line_row_reg + 1'b1;
                    if (line_row_reg < ROW_LAST) row_base_reg <= row_base_reg + ROW_STEP;
                end else begin
                    line_sub_reg <= line_sub_reg + 1'b1;
                end
            end
            if (frame)                      underrun_reg <= 1'b0;
            else if (busy && (de || line))  underrun_reg <= 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_rd_pipe
            if (gi == 0) begin : g_head
                assign vld_in[gi] = rd_active;
                assign idx_in[gi] = rd_col_reg;
            end else begin : g_tail
                assign vld_in[gi] = vld_pipe[gi-1];
                assign idx_in[gi] = idx_pipe[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            for (int i = 0; i < RD_LAT; i++) idx_pipe[i] <= '0;
        end else begin
            vld_pipe <= flush ? '0 : vld_in;
            idx_pipe <= idx_in;
        end
    end

    assign cur_col = (de && !de_q_reg) ? '0 : px_col_reg;
    assign cur_sub = (de && !de_q_reg) ? '0 : px_sub_reg;
    assign rd_idx  = (cur_col < COL_END) ? cur_col[IDXW-1:0] : COL_LAST;

    always_ff @(posedge clk) begin
        if (vld_pipe[RD_LAT-1]) lbuf[idx_pipe[RD_LAT-1]] <= fb.fb_data;
        lbuf_rd <= lbuf[rd_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_q_reg      <= 1'b0;
            px_col_reg    <= '0;
            px_sub_reg    <= '0;
            pix_de_reg    <= 1'b0;
            pix_valid_reg <= 1'b0;
        end else begin
            de_q_reg      <= de;
            pix_de_reg    <= de;
            pix_valid_reg <= de && row_valid_reg && (cur_col < COL_END);
            if (de) begin
                if (cur_sub == SUB_LAST) begin
                    px_sub_reg <= '0;
                    px_col_reg <= (cur_col < COL_END) ? cur_col + 1'b1 : cur_col;
                end else begin
                    px_sub_reg <= cur_sub + 1'b1;
                    px_col_reg <= cur_col;
                end
            end
        end
    end

    assign pix_de   = pix_de_reg;
    assign pix_cidx = pix_valid_reg ? lbuf_rd : '0;
endmodule
